// File: rtl/adder16_arbiter.sv
// Shared add/subtract datapath for NUM_REQ requesters. A round-robin arbiter
// grants one request per cycle into a single registered result slot.
module adder16_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_op1,
    input  logic [NUM_REQ*DW-1:0] req_op2,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_result,
    output logic                  rsp_carry,
    output logic [ID_W-1:0]       rsp_id
);

    typedef enum logic {EMPTY, FULL} slot_t;

    typedef struct packed {
        logic [DW-1:0]   result;
        logic            carry;
        logic [ID_W-1:0] id;
    } rsp_t;

    slot_t           state_q, state_d;
    rsp_t            rsp_q, rsp_d;
    logic [ID_W-1:0] rr_ptr, rr_ptr_d;
    logic [ID_W-1:0] gnt_id, idx;
    logic            slot_free, found, grant;
    logic [DW-1:0]   op_a, op_b;
    logic            op_sub;
    logic [DW:0]     sum;

    // A full slot that is draining this cycle can be refilled in the same cycle.
    assign slot_free = (state_q == EMPTY) || rsp_ready;

    // Scan from rr_ptr upward; ID_W-bit index arithmetic gives the wrap for free.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign grant = found && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[gnt_id] = 1'b1;
    end

    assign op_a   = req_op1[gnt_id*DW +: DW];
    assign op_b   = req_op2[gnt_id*DW +: DW];
    assign op_sub = req_sub[gnt_id];
    // Subtract as A + ~B + 1 so the carry out doubles as the no-borrow flag.
    assign sum    = {1'b0, op_a} + {1'b0, op_sub ? ~op_b : op_b} + {{DW{1'b0}}, op_sub};

    always_comb begin
        state_d  = state_q;
        rsp_d    = rsp_q;
        rr_ptr_d = rr_ptr;
        if (grant) begin
            state_d      = FULL;
            rsp_d.result = sum[DW-1:0];
            rsp_d.carry  = sum[DW];
            rsp_d.id     = gnt_id;
            rr_ptr_d     = gnt_id + ID_W'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rsp_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            rr_ptr  <= rr_ptr_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_result = rsp_q.result;
    assign rsp_carry  = rsp_q.carry;
    assign rsp_id     = rsp_q.id;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Directed bench for adder16_arbiter: reset, add/sub wrap, round-robin order,
// backpressure and mid-operation reset, all against hand-computed values.
module tb_adder16_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DW      = 16;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_op1;
    logic [NUM_REQ*DW-1:0] req_op2;
    logic [NUM_REQ-1:0]    req_sub;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DW-1:0]         rsp_result;
    logic                  rsp_carry;
    logic [ID_W-1:0]       rsp_id;

    int n_chk  = 0;
    int n_pass = 0;

    adder16_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_sub    (req_sub),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic s);
        req_op1[i*DW +: DW] = a;
        req_op2[i*DW +: DW] = b;
        req_sub[i]          = s;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [DW-1:0] r,
                           input logic c, input logic [ID_W-1:0] id);
        chk({tag, "_valid"},  32'(rsp_valid),  32'(v));
        chk({tag, "_result"}, 32'(rsp_result), 32'(r));
        chk({tag, "_carry"},  32'(rsp_carry),  32'(c));
        chk({tag, "_id"},     32'(rsp_id),     32'(id));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_op1   = '0;
        req_op2   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset with every requester asking: no grants may leak out.
        #1;
        chk("rst_ready0", 32'(req_ready), 32'h0);
        tick();
        chk("rst_ready1", 32'(req_ready), 32'h0);
        tick();
        chk("rst_ready2", 32'(req_ready), 32'h0);
        chk_rsp("rst", 1'b0, 16'h0000, 1'b0, 2'd0);
        rst       = 1'b0;
        req_valid = '0;

        // Single add on requester 0.
        set_req(0, 16'd10, 16'd20, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("add_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk_rsp("add", 1'b1, 16'd30, 1'b0, 2'd0);

        // Wrap-around add on requester 2 (pointer is 1, scan reaches 2).
        set_req(2, 16'hFFFF, 16'h0001, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk_rsp("wrap", 1'b1, 16'h0000, 1'b1, 2'd2);

        // 5 - 7 borrows: result 0xFFFE, no-borrow flag clear.
        set_req(3, 16'd5, 16'd7, 1'b1);
        req_valid = 4'b1000;
        #1;
        chk("sub1_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        chk_rsp("sub1", 1'b1, 16'hFFFE, 1'b0, 2'd3);

        // 7 - 5 = 2 with no borrow.
        set_req(3, 16'd7, 16'd5, 1'b1);
        req_valid = 4'b1000;
        #1;
        chk("sub2_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        chk_rsp("sub2", 1'b1, 16'h0002, 1'b1, 2'd3);

        // Round-robin: pointer is back at 0, all valid, one result per cycle.
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 16'(i + 1), 16'd100, 1'b0);
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            int exp_id;
            exp_id = n % NUM_REQ;
            #1;
            chk($sformatf("rr%0d_ready", n), 32'(req_ready), 32'(1 << exp_id));
            tick();
            chk_rsp($sformatf("rr%0d", n), 1'b1, 16'(101 + exp_id), 1'b0, 2'(exp_id));
        end
        req_valid = '0;

        // Drain with nothing new: slot empties but keeps the last result.
        tick();
        chk_rsp("drain", 1'b0, 16'd101, 1'b0, 2'd0);

        // Refill with 10+20 on requester 0 (pointer is 1, 0 is the only valid).
        set_req(0, 16'd10, 16'd20, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("fill_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk_rsp("fill", 1'b1, 16'd30, 1'b0, 2'd0);

        // Backpressure for 3 cycles while requester 1 waits.
        set_req(1, 16'd50, 16'd8, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("bp%0d_ready", n), 32'(req_ready), 32'h0);
            tick();
            chk_rsp($sformatf("bp%0d", n), 1'b1, 16'd30, 1'b0, 2'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk_rsp("bp_release", 1'b1, 16'd42, 1'b1, 2'd1);

        // Reset while full and stalled; pointer (now 2) must return to 0.
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 16'(i + 1), 16'd100, 1'b0);
        rsp_ready = 1'b0;
        req_valid = '1;
        rst       = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst       = 1'b0;
        chk_rsp("mid_rst", 1'b0, 16'h0000, 1'b0, 2'd0);
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk_rsp("post_rst", 1'b1, 16'd101, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
